cpu_bus_router: RTL and testbench

CPU_BUS_ROUTER -- requirements
Module: cpu_bus_router

---
 rtl/cpu_bus_router.sv | 204 ++++++++++++++++++++
 tb/tb_cpu_bus_router.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_router.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_router
// Purpose  : Routes single CPU bus accesses to either a memory port (with
//            RAM mirror folding and an expansion-window offset) or a
//            register port (with PPU register mirror folding). Memory
//            accesses wait for mem_ack under a bounded timeout; register
//            accesses complete with a fixed 3-cycle latency.
// Ports    : clk, rst_n           - clock, synchronous active-low reset
//            cpu_req/we/addr/wdata - CPU request side (sampled in IDLE only)
//            cpu_ack/rdata/err     - CPU completion (one-cycle pulse)
//            mem_*                 - memory request/handshake port
//            reg_*                 - register strobe port
// Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_router #(
    parameter logic [15:0] RAM_SIZE   = 16'h0800,
    parameter logic [15:0] PPU_BASE   = 16'h2000,
    parameter logic [15:0] PPU_REGS   = 16'd8,
    parameter logic [15:0] IO_BASE    = 16'h4000,
    parameter logic [15:0] IO_END     = 16'h4020,
    parameter logic [15:0] EXP_OFFSET = 16'h0800,
    parameter logic [7:0]  TIMEOUT    = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        reg_req,
    output logic        reg_we,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    input  logic [7:0]  reg_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_REG  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_reg_phase;   // 0: strobe cycle, 1: capture cycle
    logic [7:0]  r_tcnt;
    logic        r_err;
    logic [7:0]  r_rdata;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_reg_we;
    logic [15:0] r_reg_addr;
    logic [7:0]  r_reg_wdata;

    logic        w_is_mem;
    logic [15:0] w_tgt_addr;
    logic        w_timeout;

    // Address decode of the live CPU address; only consumed in IDLE when the
    // request is latched, so the translated address is captured once.
    always_comb begin
        w_is_mem   = 1'b1;
        w_tgt_addr = cpu_addr & (RAM_SIZE - 16'd1);
        if (cpu_addr < PPU_BASE) begin
            w_is_mem   = 1'b1;
            w_tgt_addr = cpu_addr & (RAM_SIZE - 16'd1);
        end else if (cpu_addr < IO_BASE) begin
            w_is_mem   = 1'b0;
            w_tgt_addr = PPU_BASE + (cpu_addr & (PPU_REGS - 16'd1));
        end else if (cpu_addr < IO_END) begin
            w_is_mem   = 1'b0;
            w_tgt_addr = cpu_addr;
        end else begin
            w_is_mem   = 1'b1;
            w_tgt_addr = cpu_addr - IO_END + EXP_OFFSET;
        end
    end

    // The counter starts at 0 in the first MEM cycle and is bumped by every
    // un-acked cycle; when that bump would make it reach TIMEOUT, mem_req has
    // been held for exactly TIMEOUT cycles and the access is abandoned.
    // An ack in the same cycle wins.
    assign w_timeout = (r_tcnt == (TIMEOUT - 8'd1)) && !mem_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        mem_req      = 1'b0;
        reg_req      = 1'b0;
        cpu_ack      = 1'b0;
        cpu_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    w_state_next = w_is_mem ? S_MEM : S_REG;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (mem_ack || w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_REG: begin
                reg_req = !r_reg_phase;
                if (r_reg_phase) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                cpu_ack      = 1'b1;
                cpu_err      = r_err;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_reg_phase <= 1'b0;
            r_tcnt      <= 8'd0;
            r_err       <= 1'b0;
            r_rdata     <= 8'h00;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 8'h00;
            r_reg_we    <= 1'b0;
            r_reg_addr  <= 16'h0000;
            r_reg_wdata <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_err       <= 1'b0;
                        r_tcnt      <= 8'd0;
                        r_reg_phase <= 1'b0;
                        if (w_is_mem) begin
                            r_mem_addr  <= w_tgt_addr;
                            r_mem_we    <= cpu_we;
                            r_mem_wdata <= cpu_wdata;
                        end else begin
                            r_reg_addr  <= w_tgt_addr;
                            r_reg_we    <= cpu_we;
                            r_reg_wdata <= cpu_wdata;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        r_rdata <= r_mem_we ? 8'h00 : mem_rdata;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                        if (w_timeout) begin
                            r_rdata <= 8'hFF;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_REG: begin
                    if (!r_reg_phase) begin
                        r_reg_phase <= 1'b1;
                    end else begin
                        r_rdata <= r_reg_we ? 8'h00 : reg_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cpu_rdata = r_rdata;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign reg_we    = r_reg_we;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_bus_router
// Purpose  : Self-checking bench for cpu_bus_router. Directed scenarios plus
//            randomized accesses compared against an address-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_router;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        reg_req;
    logic        reg_we;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          lat;
        int          mem_cyc;
        int          reg_cyc;
        logic [15:0] m_addr;
        logic        m_we;
        logic [7:0]  m_wdata;
        logic [15:0] r_addr;
        logic        r_we;
        logic [7:0]  r_wdata;
        logic [7:0]  rdata;
        logic        err;
        bit          both;
        bit          unstable;
        bit          got_ack;
    } obs_t;

    cpu_bus_router dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, need finished");
        $fatal(1);
    end

    // Address map reference: target selection and translated address.
    function automatic void model(input logic [15:0] a, output bit is_mem,
                                  output logic [15:0] ta);
        int ai;
        ai = int'(a);
        if (ai < 'h2000) begin
            is_mem = 1; ta = 16'(ai % 'h800);
        end else if (ai < 'h4000) begin
            is_mem = 0; ta = 16'('h2000 + ai % 8);
        end else if (ai < 'h4020) begin
            is_mem = 0; ta = a;
        end else begin
            is_mem = 1; ta = 16'((ai - 'h4020 + 'h800) % 65536);
        end
    endfunction

    // Issues one request and records what the DUT did; no judgement here.
    // ack_after < 0 means mem_ack is never given.
    task automatic run_access(input logic [15:0] a, input logic w,
                              input logic [7:0] wd, input int ack_after,
                              input logic [7:0] md, input logic [7:0] rd,
                              output obs_t o);
        bit prev_reg;
        o = '{default: 0};
        prev_reg  = 0;
        cpu_req   = 1'b1;
        cpu_addr  = a;
        cpu_we    = w;
        cpu_wdata = wd;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk); #1;
            cpu_req   = 1'b0;
            cpu_addr  = 16'($urandom);
            cpu_we    = 1'($urandom);
            cpu_wdata = 8'($urandom);
            mem_ack   = 1'b0;
            mem_rdata = ~md;
            reg_rdata = prev_reg ? rd : ~rd;
            if (mem_req && reg_req) o.both = 1;
            if (mem_req) begin
                if (o.mem_cyc == 0) begin
                    o.m_addr = mem_addr; o.m_we = mem_we; o.m_wdata = mem_wdata;
                end else if (mem_addr !== o.m_addr || mem_we !== o.m_we ||
                             mem_wdata !== o.m_wdata) begin
                    o.unstable = 1;
                end
                o.mem_cyc++;
                if (ack_after >= 0 && o.mem_cyc == ack_after + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = md;
                end
            end
            if (reg_req) begin
                o.reg_cyc++;
                o.r_addr = reg_addr; o.r_we = reg_we; o.r_wdata = reg_wdata;
            end
            prev_reg = reg_req;
            if (cpu_ack) begin
                o.got_ack = 1; o.lat = k; o.rdata = cpu_rdata; o.err = cpu_err;
                break;
            end
        end
        mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [15:0] rv[11];
        string       nm[11];
        rst_n = 1'b0; cpu_req = 1'b1; cpu_addr = 16'h0100;
        repeat (3) @(posedge clk);
        #1;
        rv = '{16'(cpu_ack), 16'(cpu_err), 16'(cpu_rdata), 16'(mem_req), 16'(mem_we),
               mem_addr, 16'(mem_wdata), 16'(reg_req), 16'(reg_we), reg_addr, 16'(reg_wdata)};
        nm = '{"cpu_ack", "cpu_err", "cpu_rdata", "mem_req", "mem_we", "mem_addr",
               "mem_wdata", "reg_req", "reg_we", "reg_addr", "reg_wdata"};
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (rv[i] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_%s: got %h, need 0000", nm[i], rv[i]);
            end
        end
        cpu_req = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b0 || reg_req !== 1'b0 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got mem_req=%b reg_req=%b cpu_ack=%b, need 0 0 0",
                     mem_req, reg_req, cpu_ack);
        end
    endtask

    task automatic test_mem_read();
        obs_t o;
        run_access(16'h1803, 1'b0, 8'h00, 2, 8'h5A, 8'h00, o);
        checks++;
        if (o.m_addr !== 16'h0003 || o.mem_cyc != 3) begin
            errors++;
            $display("FAIL mem_read_addr: got %h (%0d cycles), need 0003 (3 cycles)",
                     o.m_addr, o.mem_cyc);
        end
        checks++;
        if (!o.got_ack || o.rdata !== 8'h5A || o.err !== 1'b0 || o.lat != 4) begin
            errors++;
            $display("FAIL mem_read_resp: got ack=%0d rdata=%h err=%b lat=%0d, need 1 5A 0 4",
                     o.got_ack, o.rdata, o.err, o.lat);
        end
    endtask

    task automatic test_reg_write();
        obs_t o;
        run_access(16'h3FFE, 1'b1, 8'h11, 0, 8'h00, 8'hC3, o);
        checks++;
        if (o.reg_cyc != 1 || o.mem_cyc != 0 || o.r_we !== 1'b1 ||
            o.r_addr !== 16'h2006 || o.r_wdata !== 8'h11) begin
            errors++;
            $display("FAIL reg_write_strobe: got n=%0d mem=%0d we=%b addr=%h data=%h, need 1 0 1 2006 11",
                     o.reg_cyc, o.mem_cyc, o.r_we, o.r_addr, o.r_wdata);
        end
        checks++;
        if (!o.got_ack || o.lat != 3 || o.rdata !== 8'h00) begin
            errors++;
            $display("FAIL reg_write_resp: got ack=%0d lat=%0d rdata=%h, need 1 3 00",
                     o.got_ack, o.lat, o.rdata);
        end
    endtask

    task automatic test_exp_window();
        obs_t o;
        run_access(16'h4020, 1'b0, 8'h00, 0, 8'h9E, 8'h00, o);
        checks++;
        if (o.m_addr !== 16'h0800 || o.rdata !== 8'h9E) begin
            errors++;
            $display("FAIL exp_low: got addr=%h rdata=%h, need 0800 9E", o.m_addr, o.rdata);
        end
        run_access(16'hFFFF, 1'b0, 8'h00, 1, 8'h27, 8'h00, o);
        checks++;
        if (o.m_addr !== 16'hC7DF || o.rdata !== 8'h27) begin
            errors++;
            $display("FAIL exp_high: got addr=%h rdata=%h, need C7DF 27", o.m_addr, o.rdata);
        end
    endtask

    task automatic test_io_read();
        obs_t o;
        run_access(16'h4016, 1'b0, 8'h00, 0, 8'h00, 8'h41, o);
        checks++;
        if (o.r_addr !== 16'h4016 || o.r_we !== 1'b0 || o.rdata !== 8'h41 || o.lat != 3) begin
            errors++;
            $display("FAIL io_read: got addr=%h we=%b rdata=%h lat=%0d, need 4016 0 41 3",
                     o.r_addr, o.r_we, o.rdata, o.lat);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_access(16'h0456, 1'b0, 8'h00, -1, 8'h00, 8'h00, o);
        checks++;
        if (o.mem_cyc != 255 || o.unstable) begin
            errors++;
            $display("FAIL timeout_len: got %0d mem_req cycles (unstable=%0d), need 255 (0)",
                     o.mem_cyc, o.unstable);
        end
        checks++;
        if (!o.got_ack || o.err !== 1'b1 || o.rdata !== 8'hFF || o.lat != 256) begin
            errors++;
            $display("FAIL timeout_resp: got ack=%0d err=%b rdata=%h lat=%0d, need 1 1 FF 256",
                     o.got_ack, o.err, o.rdata, o.lat);
        end
        run_access(16'h0010, 1'b0, 8'h00, 0, 8'h3C, 8'h00, o);
        checks++;
        if (o.err !== 1'b0 || o.rdata !== 8'h3C) begin
            errors++;
            $display("FAIL timeout_recover: got err=%b rdata=%h, need 0 3C", o.err, o.rdata);
        end
    endtask

    task automatic test_reset_mid_mem();
        obs_t o;
        bit   bad;
        cpu_req = 1'b1; cpu_addr = 16'h0123; cpu_we = 1'b0; cpu_wdata = 8'h00;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup: got mem_req=%b, need 1", mem_req);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b0 || cpu_ack !== 1'b0 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_drop: got mem_req=%b cpu_ack=%b mem_addr=%h, need 0 0 0000",
                     mem_req, cpu_ack, mem_addr);
        end
        rst_n   = 1'b1;
        mem_ack = 1'b1;   // stray ack while idle must do nothing
        bad     = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (cpu_ack !== 1'b0 || mem_req !== 1'b0) bad = 1;
        end
        mem_ack = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rst_mid_noack: got activity after abandoned access, need none");
        end
        run_access(16'h0777, 1'b0, 8'h00, 0, 8'hA5, 8'h00, o);
        checks++;
        if (o.rdata !== 8'hA5 || o.err !== 1'b0 || o.m_addr !== 16'h0777) begin
            errors++;
            $display("FAIL rst_mid_recover: got rdata=%h err=%b addr=%h, need A5 0 0777",
                     o.rdata, o.err, o.m_addr);
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        bit seen;
        cpu_req = 1'b1; cpu_addr = 16'h2005; cpu_we = 1'b0; cpu_wdata = 8'h00;
        reg_rdata = 8'h77;
        cnt = 0; seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (reg_req) cnt++;
            if (cpu_ack) begin seen = 1; break; end
        end
        checks++;
        if (!seen || cnt != 1 || cpu_rdata !== 8'h77) begin
            errors++;
            $display("FAIL b2b_first: got ack=%0d reg_req count=%0d rdata=%h, need 1 1 77",
                     seen, cnt, cpu_rdata);
        end
        @(posedge clk); #1;
        checks++;
        if (reg_req !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early: got reg_req=%b mem_req=%b in ack+1 cycle, need 0 0",
                     reg_req, mem_req);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        checks++;
        if (reg_req !== 1'b1 || reg_addr !== 16'h2005) begin
            errors++;
            $display("FAIL b2b_accept: got reg_req=%b addr=%h, need 1 2005", reg_req, reg_addr);
        end
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (cpu_ack) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_second: got no ack, need ack");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        obs_t        o;
        logic [15:0] a, ta, got_addr;
        logic        w, got_we, got_wd_ok;
        logic [7:0]  wd, md, rd, exp_rd;
        int          ack_after, exp_lat;
        bit          is_mem;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 16'($urandom_range(16'h0000, 16'h1FFF));
                1:       a = 16'($urandom_range(16'h2000, 16'h3FFF));
                2:       a = 16'($urandom_range(16'h4000, 16'h401F));
                default: a = 16'($urandom_range(16'h4020, 16'hFFFF));
            endcase
            w         = 1'($urandom);
            wd        = 8'($urandom);
            md        = 8'($urandom);
            rd        = 8'($urandom);
            ack_after = $urandom_range(0, 5);
            model(a, is_mem, ta);
            run_access(a, w, wd, ack_after, md, rd, o);
            exp_rd    = w ? 8'h00 : (is_mem ? md : rd);
            exp_lat   = is_mem ? ack_after + 2 : 3;
            got_addr  = is_mem ? o.m_addr : o.r_addr;
            got_we    = is_mem ? o.m_we : o.r_we;
            got_wd_ok = !w || ((is_mem ? o.m_wdata : o.r_wdata) === wd);
            checks++;
            if (o.mem_cyc != (is_mem ? ack_after + 1 : 0) || o.reg_cyc != (is_mem ? 0 : 1)) begin
                errors++;
                $display("FAIL rnd_route a=%h: got mem=%0d reg=%0d cycles, need %0d %0d",
                         a, o.mem_cyc, o.reg_cyc, is_mem ? ack_after + 1 : 0, is_mem ? 0 : 1);
            end
            checks++;
            if (got_addr !== ta || got_we !== w || !got_wd_ok) begin
                errors++;
                $display("FAIL rnd_addr a=%h: got addr=%h we=%b wdata_ok=%b, need %h %b 1",
                         a, got_addr, got_we, got_wd_ok, ta, w);
            end
            checks++;
            if (!o.got_ack || o.lat != exp_lat || o.rdata !== exp_rd || o.err !== 1'b0) begin
                errors++;
                $display("FAIL rnd_resp a=%h: got ack=%0d lat=%0d rdata=%h err=%b, need 1 %0d %h 0",
                         a, o.got_ack, o.lat, o.rdata, o.err, exp_lat, exp_rd);
            end
            checks++;
            if (o.both || o.unstable) begin
                errors++;
                $display("FAIL rnd_bus a=%h: got overlap=%0d unstable=%0d, need 0 0",
                         a, o.both, o.unstable);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        mem_rdata = 8'h00;
        mem_ack   = 1'b0;
        reg_rdata = 8'h00;
        @(posedge clk); #1;
        test_reset();
        test_mem_read();
        test_reg_write();
        test_exp_window();
        test_io_read();
        test_timeout();
        test_reset_mid_mem();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
